// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared types and constants for the multdiv sequencing controller.
//   md_state_e  - controller FSM states
//   OP_*        - request opcode encoding (req_op)
//   RSTATUS_REG - register that receives the status code on an exception
//   EXC_*       - status codes written on mult overflow / divide-by-zero
package multdiv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_DONE,
    S_DRAIN
  } md_state_e;

  localparam logic        OP_MULT     = 1'b0;
  localparam logic        OP_DIV      = 1'b1;
  localparam logic [4:0]  RSTATUS_REG = 5'd30;
  localparam logic [31:0] EXC_MULT    = 32'd4;
  localparam logic [31:0] EXC_DIV     = 32'd5;

  // Status code reported for an excepting operation of the given type.
  function automatic logic [31:0] exc_code(input logic op);
    return (op == OP_DIV) ? EXC_DIV : EXC_MULT;
  endfunction

endpackage

// File: rtl/multdiv_ctrl_if.sv
// multdiv_ctrl_if: bundles the execute-stage request, multdiv unit and
// writeback handshakes of the controller.
//   slave  - the controller's view (consumes requests, drives multdiv/writeback)
//   master - the surrounding pipeline / multdiv unit / register file view
interface multdiv_ctrl_if;
  // execute stage request
  logic        req_valid;
  logic        req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_rd;
  logic        req_ready;
  logic        flush;
  logic        stall;
  // multdiv unit
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic [31:0] md_result;
  logic        md_except;
  logic        md_ready;
  // writeback
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ack;
  logic        timeout_err;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_rd, flush,
           md_result, md_except, md_ready, wb_ack,
    output req_ready, stall, md_a, md_b, md_ctrl_mult, md_ctrl_div,
           wb_valid, wb_rd, wb_data, timeout_err
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_rd, flush,
           md_result, md_except, md_ready, wb_ack,
    input  req_ready, stall, md_a, md_b, md_ctrl_mult, md_ctrl_div,
           wb_valid, wb_rd, wb_data, timeout_err
  );
endinterface

// File: rtl/md_timeout_ctr.sv
// md_timeout_ctr: watchdog counter for one multdiv operation.
//   clock, reset_n - clock / async active-low reset
//   clr_i          - zero the count (operation start)
//   en_i           - count one cycle
//   tc_o           - high during the TIMEOUT_CYCLES-th enabled cycle after clr_i
module md_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The count holds the number of already-completed cycles, so the cycle in
  // which it reads TIMEOUT_CYCLES-1 is the one that brings it to the limit.
  assign tc_o = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)             cnt_d = '0;
    else if (en_i && !tc_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequences one mult/div at a time through the iterative
// multdiv unit and returns the result over a valid/ack writeback.
//   clock, reset_n - clock / async active-low reset
//   bus            - request, multdiv and writeback signals (slave modport)
// IDLE -> START (one-cycle start pulse) -> BUSY (wait md_ready, watchdog)
//   -> DONE (hold writeback until wb_ack) -> IDLE.
// A flush in START/BUSY parks the FSM in DRAIN until multdiv finishes or the
// watchdog expires, so a later START never overlaps a running operation.
module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic           clock,
  input logic           reset_n,
  multdiv_ctrl_if.slave bus
);

  md_state_e   state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic        ctr_clr, ctr_en, ctr_tc;
  logic        timeout_pulse;
  logic [4:0]  res_rd;
  logic [31:0] res_data;

  md_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clr_i   (ctr_clr),
    .en_i    (ctr_en),
    .tc_o    (ctr_tc)
  );

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    rd_d          = rd_q;
    wb_rd_d       = wb_rd_q;
    wb_data_d     = wb_data_q;
    ctr_clr       = 1'b0;
    ctr_en        = 1'b0;
    timeout_pulse = 1'b0;
    // resolved writeback for an md_ready in this cycle
    res_rd        = bus.md_except ? RSTATUS_REG : rd_q;
    res_data      = bus.md_except ? exc_code(op_q) : bus.md_result;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid && !bus.flush) begin
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          op_d    = bus.req_op;
          rd_d    = bus.req_rd;
          state_d = S_START;
        end
      end
      // md_ready is not looked at here: it may still be up from the
      // previous operation.
      S_START: begin
        ctr_clr = 1'b1;
        state_d = bus.flush ? S_DRAIN : S_BUSY;
      end
      // Priority: flush > md_ready > watchdog.
      S_BUSY: begin
        ctr_en = 1'b1;
        if (bus.flush) begin
          state_d = S_DRAIN;
        end else if (bus.md_ready) begin
          if (res_rd == 5'd0) begin
            state_d = S_IDLE;
          end else begin
            wb_rd_d   = res_rd;
            wb_data_d = res_data;
            state_d   = S_DONE;
          end
        end else if (ctr_tc) begin
          timeout_pulse = 1'b1;
          state_d       = S_IDLE;
        end
      end
      // Result belongs to a committed instruction, so flush is not honoured.
      S_DONE: begin
        if (bus.wb_ack) state_d = S_IDLE;
      end
      S_DRAIN: begin
        ctr_en = 1'b1;
        if (bus.md_ready || ctr_tc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_MULT;
      rd_q      <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign bus.req_ready    = (state_q == S_IDLE);
  assign bus.stall        = (state_q == S_START) || (state_q == S_BUSY) ||
                            (state_q == S_DONE);
  assign bus.md_a         = a_q;
  assign bus.md_b         = b_q;
  assign bus.md_ctrl_mult = (state_q == S_START) && (op_q == OP_MULT);
  assign bus.md_ctrl_div  = (state_q == S_START) && (op_q == OP_DIV);
  assign bus.wb_valid     = (state_q == S_DONE);
  assign bus.wb_rd        = wb_rd_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.timeout_err  = timeout_pulse;

endmodule
